// File: rtl/buf_share_arb.sv
// buf_share_arb: round-robin arbiter that relays one four-phase req/ack
// handshake at a time from N_REQ senders onto a single BUF input port.
// Optional macro BUF_ARB_TIMEOUT_EN adds a b_ack watchdog in FWD that sets
// the sticky err flag and abandons the transfer after TIMEOUT cycles.
module buf_share_arb #(
   parameter int N_REQ   = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic [N_REQ-1:0]                               s_req,
   input  logic [N_REQ*DW-1:0]                            s_data,
   output logic [N_REQ-1:0]                               s_ack,
   output logic                                           b_req,
   output logic [DW-1:0]                                  b_data,
   input  logic                                           b_ack,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]   gnt_id,
   output logic                                           busy,
   output logic                                           err
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IW:0]   N_W  = (IW+1)'(N_REQ);
   localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [IW-1:0]       ptr_r;
   logic [IW-1:0]       ptr_nxt_s;
   logic [IW-1:0]       gnt_nxt_s;
   logic [DW-1:0]       data_nxt_s;
   logic                breq_nxt_s;
   logic [N_REQ-1:0]    sack_nxt_s;
   logic                busy_nxt_s;
   logic [IW-1:0]       pick_s;
   logic [IW-1:0]       ptr_after_s;
   logic [DW-1:0]       data_arr_s [N_REQ];

   // First requester at or after ptr, scanning upward with wrap. Scanning
   // downward in k lets the smallest distance from ptr overwrite last.
   function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IW-1:0]    ptr);
      logic [IW-1:0] pick;
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      pick = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum  = {1'b0, ptr} + (IW+1)'(k);
         sum  = (sum >= N_W) ? (sum - N_W) : sum;
         idx  = sum[IW-1:0];
         pick = req[idx] ? idx : pick;
      end
      return pick;
   endfunction

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr_s[g] = s_data[g*DW +: DW];
   end

   assign pick_s      = rr_pick(s_req, ptr_r);
   assign ptr_after_s = (gnt_id == LAST) ? '0 : (gnt_id + IW'(1));

`ifdef BUF_ARB_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          err_r;
   logic          err_nxt_s;

   assign err = err_r;
`else
   // Watchdog compiled out: err can never assert and TIMEOUT has no effect.
   assign err = (TIMEOUT > 0) ? 1'b0 : 1'b0;
`endif

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      gnt_nxt_s   = gnt_id;
      data_nxt_s  = b_data;
      breq_nxt_s  = b_req;
      sack_nxt_s  = s_ack;
`ifdef BUF_ARB_TIMEOUT_EN
      cnt_nxt_s   = cnt_r;
      err_nxt_s   = err_r;
`endif
      case (state_r)
         IDLE: begin
            // A stale b_ack from the previous transfer blocks a new grant.
            if ((|s_req) && !b_ack) begin
               gnt_nxt_s   = pick_s;
               data_nxt_s  = data_arr_s[pick_s];
               breq_nxt_s  = 1'b1;
               state_nxt_s = FWD;
`ifdef BUF_ARB_TIMEOUT_EN
               cnt_nxt_s   = '0;
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FWD: begin
            // An early drop of s_req is ignored here; only b_ack matters.
            if (b_ack) begin
               sack_nxt_s         = '0;
               sack_nxt_s[gnt_id] = 1'b1;
               state_nxt_s        = HOLD;
            end
`ifdef BUF_ARB_TIMEOUT_EN
            else if (cnt_r == TO_LAST) begin
               err_nxt_s   = 1'b1;
               breq_nxt_s  = 1'b0;
               ptr_nxt_s   = ptr_after_s;
               state_nxt_s = IDLE;
            end else begin
               cnt_nxt_s   = cnt_r + CW'(1);
            end
`else
            else begin
               state_nxt_s = FWD;
            end
`endif
         end
         HOLD: begin
            if (!s_req[gnt_id]) begin
               breq_nxt_s  = 1'b0;
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         DRAIN: begin
            if (!b_ack) begin
               sack_nxt_s  = '0;
               ptr_nxt_s   = ptr_after_s;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            breq_nxt_s  = 1'b0;
            sack_nxt_s  = '0;
            state_nxt_s = IDLE;
         end
      endcase
      busy_nxt_s = (state_nxt_s != IDLE);
   end

   // State and registered outputs; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ptr_r   <= '0;
         gnt_id  <= '0;
         b_data  <= '0;
         b_req   <= 1'b0;
         s_ack   <= '0;
         busy    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ptr_r   <= ptr_nxt_s;
         gnt_id  <= gnt_nxt_s;
         b_data  <= data_nxt_s;
         b_req   <= breq_nxt_s;
         s_ack   <= sack_nxt_s;
         busy    <= busy_nxt_s;
      end
   end

`ifdef BUF_ARB_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
         err_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         err_r <= err_nxt_s;
      end
   end
`endif

endmodule

// File: tb/tb_buf_share_arb.sv
// Directed self-checking bench for buf_share_arb (N_REQ=4, DW=32).
// With BUF_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT=8.
module tb_buf_share_arb;

   localparam int N  = 4;
   localparam int DW = 32;
`ifdef BUF_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_req;
   logic [N*DW-1:0] s_data;
   logic [N-1:0]    s_ack;
   logic            b_req;
   logic [DW-1:0]   b_data;
   logic            b_ack;
   logic [1:0]      gnt_id;
   logic            busy;
   logic            err;

   int checks = 0;
   int errors = 0;

   buf_share_arb #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_req  (s_req),
      .s_data (s_data),
      .s_ack  (s_ack),
      .b_req  (b_req),
      .b_data (b_data),
      .b_ack  (b_ack),
      .gnt_id (gnt_id),
      .busy   (busy),
      .err    (err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      checks++; if (s_ack !== 4'b0000) begin errors++; $display("FAIL rst_sack got %b want 0000", s_ack); end
      checks++; if (b_req !== 1'b0) begin errors++; $display("FAIL rst_breq got %b want 0", b_req); end
      checks++; if (b_data !== 32'h0) begin errors++; $display("FAIL rst_bdata got %h want 0", b_data); end
      checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL rst_gnt got %0d want 0", gnt_id); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_busy_err got %b%b want 00", busy, err); end
      tick;
      rst_n = 1'b1;
      tick;
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_single;
      s_data = '0;
      s_data[1*DW +: DW] = 32'h2A;
      s_req = 4'b0010;
      checks++; if (b_req !== 1'b0) begin errors++; $display("FAIL single_pre_breq got %b want 0", b_req); end
      tick;
      checks++; if (b_req !== 1'b1) begin errors++; $display("FAIL single_breq got %b want 1", b_req); end
      checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL single_gnt got %0d want 1", gnt_id); end
      checks++; if (b_data !== 32'h2A) begin errors++; $display("FAIL single_bdata got %h want 2a", b_data); end
      checks++; if (busy !== 1'b1 || s_ack !== 4'b0000) begin errors++; $display("FAIL single_grant busy=%b sack=%b want 1 0000", busy, s_ack); end
      tick;
      tick;
      b_ack = 1'b1;
      tick;
      checks++; if (s_ack !== 4'b0010) begin errors++; $display("FAIL single_sack got %b want 0010", s_ack); end
      s_req = 4'b0000;
      tick;
      checks++; if (b_req !== 1'b0 || s_ack !== 4'b0010) begin errors++; $display("FAIL single_drain breq=%b sack=%b want 0 0010", b_req, s_ack); end
      b_ack = 1'b0;
      tick;
      checks++; if (s_ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_end sack=%b busy=%b want 0000 0", s_ack, busy); end
      checks++; if (b_data !== 32'h2A) begin errors++; $display("FAIL single_bdata_hold got %h want 2a", b_data); end
   endtask

   task automatic test_contention;
      apply_reset;
      s_data = {32'd3, 32'd2, 32'd1, 32'd0};
      s_req  = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick;
         checks++; if (gnt_id !== 2'(k) || b_req !== 1'b1) begin errors++; $display("FAIL cont_gnt got %0d breq %b want %0d 1", gnt_id, b_req, k); end
         checks++; if (b_data !== 32'(k)) begin errors++; $display("FAIL cont_bdata got %h want %h", b_data, 32'(k)); end
         b_ack = 1'b1;
         tick;
         checks++; if (s_ack !== (4'b0001 << k)) begin errors++; $display("FAIL cont_sack got %b want %b", s_ack, 4'b0001 << k); end
         s_req[k] = 1'b0;
         tick;
         checks++; if (b_req !== 1'b0) begin errors++; $display("FAIL cont_breq_low got %b want 0", b_req); end
         b_ack = 1'b0;
         tick;
         checks++; if (s_ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL cont_end sack=%b busy=%b want 0000 0", s_ack, busy); end
         s_req[k] = 1'b1;
      end
   endtask

   task automatic test_wrap;
      int exp_g [2] = '{0, 3};
      s_req = 4'b1001;
      for (int k = 0; k < 2; k++) begin
         tick;
         checks++; if (gnt_id !== 2'(exp_g[k])) begin errors++; $display("FAIL wrap_gnt got %0d want %0d", gnt_id, exp_g[k]); end
         b_ack = 1'b1;
         tick;
         s_req[exp_g[k]] = 1'b0;
         tick;
         b_ack = 1'b0;
         tick;
         s_req[exp_g[k]] = 1'b1;
      end
      s_req = 4'b0000;
      tick;
   endtask

   task automatic test_stale_ack;
      b_ack = 1'b1;
      s_req = 4'b0010;
      tick;
      tick;
      checks++; if (b_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stale_ack breq=%b busy=%b want 0 0", b_req, busy); end
      b_ack = 1'b0;
      tick;
      checks++; if (b_req !== 1'b1 || gnt_id !== 2'd1) begin errors++; $display("FAIL stale_grant breq=%b gnt=%0d want 1 1", b_req, gnt_id); end
      b_ack = 1'b1;
      tick;
      s_req = 4'b0000;
      tick;
      b_ack = 1'b0;
      tick;
   endtask

   task automatic test_early_drop;
      apply_reset;
      s_data[0 +: DW] = 32'h55;
      s_req = 4'b0001;
      tick;
      checks++; if (gnt_id !== 2'd0 || b_data !== 32'h55) begin errors++; $display("FAIL drop_grant gnt=%0d data=%h want 0 55", gnt_id, b_data); end
      s_req = 4'b0000;
      tick;
      tick;
      checks++; if (b_req !== 1'b1 || s_ack !== 4'b0000) begin errors++; $display("FAIL drop_fwd breq=%b sack=%b want 1 0000", b_req, s_ack); end
      b_ack = 1'b1;
      tick;
      checks++; if (s_ack !== 4'b0001) begin errors++; $display("FAIL drop_sack got %b want 0001", s_ack); end
      tick;
      checks++; if (b_req !== 1'b0) begin errors++; $display("FAIL drop_hold_pass got %b want 0", b_req); end
      b_ack = 1'b0;
      tick;
      checks++; if (s_ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL drop_end sack=%b busy=%b want 0000 0", s_ack, busy); end
   endtask

   task automatic test_reset_hold;
      apply_reset;
      s_data = {32'd3, 32'd2, 32'd1, 32'd0};
      // First transfer to 2 leaves the rr pointer at 3.
      s_req = 4'b0100;
      tick;
      b_ack = 1'b1;
      tick;
      s_req = 4'b0000;
      tick;
      b_ack = 1'b0;
      tick;
      s_req = 4'b0100;
      tick;
      checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL rh_gnt got %0d want 2", gnt_id); end
      b_ack = 1'b1;
      tick;
      checks++; if (s_ack !== 4'b0100) begin errors++; $display("FAIL rh_sack got %b want 0100", s_ack); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (s_ack !== 4'b0000 || b_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rh_abort sack=%b breq=%b busy=%b want 0000 0 0", s_ack, b_req, busy); end
      checks++; if (gnt_id !== 2'd0 || b_data !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL rh_abort2 gnt=%0d data=%h err=%b want 0 0 0", gnt_id, b_data, err); end
      b_ack = 1'b0;
      // Sender 3 also requests: a surviving pointer of 3 would pick it.
      s_req = 4'b1100;
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      checks++; if (gnt_id !== 2'd2 || b_req !== 1'b1) begin errors++; $display("FAIL rh_regrant gnt=%0d breq=%b want 2 1", gnt_id, b_req); end
      b_ack = 1'b1;
      tick;
      s_req = 4'b0000;
      tick;
      b_ack = 1'b0;
      tick;
   endtask

   task automatic test_timeout;
      int bad;
      apply_reset;
      b_ack = 1'b0;
      bad   = 0;
`ifdef BUF_ARB_TIMEOUT_EN
      s_req = 4'b0011;
      tick;
      checks++; if (gnt_id !== 2'd0 || b_req !== 1'b1) begin errors++; $display("FAIL to_grant gnt=%0d breq=%b want 0 1", gnt_id, b_req); end
      for (int i = 1; i < 8; i++) begin
         tick;
         if (b_req !== 1'b1 || err !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL to_wait bad_cycles %0d want 0", bad); end
      tick;
      checks++; if (b_req !== 1'b0 || err !== 1'b1 || s_ack !== 4'b0000) begin errors++; $display("FAIL to_expire breq=%b err=%b sack=%b want 0 1 0000", b_req, err, s_ack); end
      tick;
      checks++; if (gnt_id !== 2'd1 || b_req !== 1'b1) begin errors++; $display("FAIL to_next gnt=%0d breq=%b want 1 1", gnt_id, b_req); end
      repeat (12) tick;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", err); end
      s_req = 4'b0000;
      apply_reset;
`else
      s_req = 4'b0001;
      tick;
      checks++; if (gnt_id !== 2'd0 || b_req !== 1'b1) begin errors++; $display("FAIL nto_grant gnt=%0d breq=%b want 0 1", gnt_id, b_req); end
      repeat (200) begin
         tick;
         if (b_req !== 1'b1 || err !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL nto_hold bad_cycles %0d want 0", bad); end
      b_ack = 1'b1;
      tick;
      checks++; if (s_ack !== 4'b0001) begin errors++; $display("FAIL nto_sack got %b want 0001", s_ack); end
      s_req = 4'b0000;
      tick;
      b_ack = 1'b0;
      tick;
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL nto_end busy=%b err=%b want 0 0", busy, err); end
`endif
   endtask

   // Scenario sequence and summary.
   initial begin
      rst_n  = 1'b0;
      s_req  = '0;
      s_data = '0;
      b_ack  = 1'b0;
      test_reset;
      test_single;
      test_contention;
      test_wrap;
      test_stale_ack;
      test_early_drop;
      test_reset_hold;
      test_timeout;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
